// File: rtl/sdram_arbiter.sv
// SDRAM command arbiter: sequences init, refresh, write and read engines
// onto one bus, with refresh scheduling and a per-operation watchdog.
module sdram_arbiter #(
    parameter int REFRESH_PERIOD = 780,
    parameter int TIMEOUT        = 255
) (
    input  logic iclk,
    input  logic ireset,
    output logic oinit_req,
    output logic oinit_enb,
    input  logic iinit_fin,
    output logic oref_req,
    output logic oref_enb,
    input  logic iref_fin,
    output logic owr_req,
    output logic owr_enb,
    input  logic iwr_fin,
    output logic ord_req,
    output logic ord_enb,
    input  logic ird_fin,
    input  logic iuser_wr,
    input  logic iuser_rd,
    output logic owr_done,
    output logic ord_done,
    output logic oready,
    output logic oerr
);

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        REFRESH,
        WRITE,
        READ
    } state_t;

    localparam logic [15:0] REF_LAST = 16'(REFRESH_PERIOD - 1);
    localparam logic [8:0]  WD_LAST  = 9'(TIMEOUT - 1);

    state_t      state;
    logic [15:0] ref_cnt;
    logic        ref_pend;
    logic [7:0]  wd;
    logic        timeout;
    logic        wr_ok;
    logic        rd_ok;

    assign timeout = ({1'b0, wd} == WD_LAST);
    // The request just served is still high while its done pulse is out.
    assign wr_ok   = iuser_wr & ~owr_done;
    assign rd_ok   = iuser_rd & ~ord_done;

    always_ff @(posedge iclk) begin
        if (ireset || state == INIT) begin
            ref_cnt  <= '0;
            ref_pend <= 1'b0;
        end else if (state == IDLE && ref_pend) begin
            ref_cnt  <= '0;
            ref_pend <= 1'b0;
        end else begin
            if (ref_cnt != REF_LAST)
                ref_cnt <= ref_cnt + 16'd1;
            if (ref_cnt == REF_LAST)
                ref_pend <= 1'b1;
        end
    end

    always_ff @(posedge iclk) begin
        oinit_req <= 1'b0;
        oref_req  <= 1'b0;
        owr_req   <= 1'b0;
        ord_req   <= 1'b0;
        owr_done  <= 1'b0;
        ord_done  <= 1'b0;
        if (ireset) begin
            state     <= INIT;
            oinit_enb <= 1'b0;
            oref_enb  <= 1'b0;
            owr_enb   <= 1'b0;
            ord_enb   <= 1'b0;
            oready    <= 1'b0;
            oerr      <= 1'b0;
            wd        <= '0;
        end else begin
            unique case (state)
                INIT: begin
                    if (!oinit_enb) begin
                        oinit_req <= 1'b1;
                        oinit_enb <= 1'b1;
                        wd        <= '0;
                    end else if (iinit_fin) begin
                        oinit_enb <= 1'b0;
                        oready    <= 1'b1;
                        state     <= IDLE;
                    end else if (timeout) begin
                        oinit_req <= 1'b1;
                        oerr      <= 1'b1;
                        wd        <= '0;
                    end else begin
                        wd <= wd + 8'd1;
                    end
                end
                IDLE: begin
                    wd <= '0;
                    if (ref_pend) begin
                        state    <= REFRESH;
                        oref_req <= 1'b1;
                        oref_enb <= 1'b1;
                    end else if (wr_ok) begin
                        state   <= WRITE;
                        owr_req <= 1'b1;
                        owr_enb <= 1'b1;
                    end else if (rd_ok) begin
                        state   <= READ;
                        ord_req <= 1'b1;
                        ord_enb <= 1'b1;
                    end
                end
                REFRESH: begin
                    if (iref_fin || timeout) begin
                        state    <= IDLE;
                        oref_enb <= 1'b0;
                        if (!iref_fin)
                            oerr <= 1'b1;
                    end else begin
                        wd <= wd + 8'd1;
                    end
                end
                WRITE: begin
                    if (iwr_fin || timeout) begin
                        state    <= IDLE;
                        owr_enb  <= 1'b0;
                        owr_done <= 1'b1;
                        if (!iwr_fin)
                            oerr <= 1'b1;
                    end else begin
                        wd <= wd + 8'd1;
                    end
                end
                READ: begin
                    if (ird_fin || timeout) begin
                        state    <= IDLE;
                        ord_enb  <= 1'b0;
                        ord_done <= 1'b1;
                        if (!ird_fin)
                            oerr <= 1'b1;
                    end else begin
                        wd <= wd + 8'd1;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter REFRESH_PERIOD, default 780, gives cycles between refresh requests; legal range 2..65535.
REQ-002 Parameter TIMEOUT, default 255, gives the maximum cycles any granted operation may run before it is aborted; legal range 1..255.
REQ-003 iclk  in  1  single clock; all state changes occur on its rising edge.
REQ-004 ireset  in  1  synchronous, active-high reset.
REQ-005 oinit_req, oinit_enb  out  1 each  request pulse and bus enable for the init engine; iinit_fin  in  1  init done.
REQ-006 oref_req, oref_enb  out  1 each  request pulse and bus enable for the refresh engine; iref_fin  in  1  refresh done.
REQ-007 owr_req, owr_enb  out  1 each  request pulse and bus enable for the write engine; iwr_fin  in  1  write done.
REQ-008 ord_req, ord_enb  out  1 each  request pulse and bus enable for the read engine; ird_fin  in  1  read done.
REQ-009 iuser_wr, iuser_rd  in  1 each  user write and read requests, level, held until the matching done pulse.
REQ-010 owr_done, ord_done  out  1 each  one-cycle completion pulses to the user.
REQ-011 oready  out  1  high once init is complete.
REQ-012 oerr  out  1  sticky timeout flag.

Function
REQ-013 The FSM states SHALL be INIT, IDLE, REFRESH, WRITE and READ.
REQ-014 All outputs SHALL be registered.
REQ-015 Exactly one oX_enb SHALL be high in INIT, REFRESH, WRITE or READ, and none in IDLE.
REQ-016 On entering an operation state, the matching oX_req SHALL be high for exactly the first cycle of that state, concurrent with the rise of oX_enb.
REQ-017 INIT SHALL hold oinit_enb until iinit_fin is sampled high, then go to IDLE; oready SHALL rise on that same transition and stay high until reset.
REQ-018 In IDLE, a decision SHALL be made every cycle with priority refresh_pending > iuser_wr > iuser_rd; if nothing is asserted, the FSM SHALL stay in IDLE.
REQ-019 The FSM SHALL pass through at least one IDLE cycle between any two operations.
REQ-020 Latency: a request sampled in IDLE at cycle t SHALL put the FSM in the operation state at t+1.
REQ-021 Completion: iX_fin sampled high at cycle f SHALL put the FSM in IDLE at f+1, with oX_enb low at f+1.
REQ-022 For a write, owr_done SHALL be high for cycle f+1 only; for a read, ord_done SHALL be high for cycle f+1 only.
REQ-023 The refresh counter SHALL be 16-bit and held at 0 while in INIT.
REQ-024 Outside INIT, the refresh counter SHALL increment every cycle and saturate at REFRESH_PERIOD-1.
REQ-025 When the refresh counter equals REFRESH_PERIOD-1, refresh_pending SHALL set.
REQ-026 On entry to REFRESH, the refresh counter and refresh_pending SHALL both clear.
REQ-027 A refresh that becomes pending during WRITE or READ SHALL NOT preempt it; it SHALL be serviced at the next IDLE decision, ahead of user requests.
REQ-028 Simultaneous iuser_wr and iuser_rd SHALL grant the write first; the read SHALL be granted after owr_done if it is still asserted.
REQ-029 fin inputs from engines that are not currently enabled SHALL be ignored.
REQ-030 An 8-bit watchdog SHALL clear on entry to each operation state and increment every cycle in that state.
REQ-031 If the watchdog reaches TIMEOUT with no fin, the FSM SHALL go to IDLE next cycle and set oerr.
REQ-032 A timed-out WRITE or READ SHALL still pulse its done output.
REQ-033 A timed-out INIT SHALL re-enter INIT with a fresh oinit_req.

Reset
REQ-034 While ireset is sampled high, the FSM SHALL be in INIT; all req, enb and done outputs, oready and oerr SHALL be 0; refresh counter, refresh_pending and watchdog SHALL be 0.
REQ-035 In the first cycle after ireset falls, oinit_req and oinit_enb SHALL both be 1.
REQ-036 Reset asserted mid-operation SHALL drop all enables on the next edge with no done pulse and restart from INIT.

Verification
REQ-037 Init: release reset, assert iinit_fin at cycle 10 -> oinit_enb high cycles 1..10, oready=1 and FSM in IDLE at cycle 11.
REQ-038 Write: in IDLE, iuser_wr=1 at t, iwr_fin at t+20 -> owr_req high at t+1 only, owr_enb high t+1..t+20, owr_done high at t+21 only.
REQ-039 Contention: REFRESH_PERIOD=16, iuser_wr and iuser_rd held, counter reaches 15 mid-write -> grant order write, refresh, read, each separated by one IDLE cycle.
REQ-040 Timeout: TIMEOUT=4, grant a read with ird_fin never asserted -> ord_enb high for 4 cycles, then IDLE, ord_done pulses once, oerr stays 1.
REQ-041 Reset mid-write: assert ireset during owr_enb -> next cycle all enables 0, owr_done 0, oready 0; after release, oinit_req=1.
REQ-042 Stray fin: pulse ird_fin while in WRITE -> no state change and no ord_done.
